// File: rtl/fht_stream_io.sv
// fht_stream_io: serial sample stream into the banked FHT RAMs, core
// start/completion handshake, natural-order result stream out.
module fht_stream_io #(
    parameter int D_BIT  = 16,
    parameter int A_BIT  = 8,
    parameter int N_BANK = 4,
    parameter int B_BIT  = 2,
    parameter int TO_CYC = 16
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iS_VALID,
    output logic                    oS_READY,
    input  logic [D_BIT-2:0]        iS_DATA,
    output logic [N_BANK-1:0]       oWE,
    output logic [A_BIT-1:0]        oADDR_WR,
    output logic [D_BIT-1:0]        oDATA_WR,
    output logic                    oSTART,
    input  logic                    iRDY,
    output logic [A_BIT-1:0]        oADDR_RD,
    input  logic [N_BANK*D_BIT-1:0] iDATA_RD,
    output logic                    oM_VALID,
    input  logic                    iM_READY,
    output logic [D_BIT-1:0]        oM_DATA,
    output logic                    oM_LAST,
    output logic                    oBUSY,
    output logic                    oERR
);
    localparam int CW = B_BIT + A_BIT;
    localparam int TW = $clog2(TO_CYC + 1);
    localparam int VW = N_BANK * D_BIT;
    localparam logic [TW-1:0]    TO_LIM = TW'(TO_CYC - 2);
    localparam logic [CW-1:0]    LAST_N = '1;
    localparam logic [B_BIT-1:0] LAST_K = '1;
    localparam logic [A_BIT-1:0] LAST_A = '1;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_LO, WAIT_HI, UNLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    to_q, to_d;
    logic             err_q, err_d;
    logic [A_BIT-1:0] addr_q, addr_d;
    logic             rdv_q, rdv_d;
    logic             infl_q, infl_d;
    logic [VW-1:0]    cur_q, cur_d;
    logic             cur_v_q, cur_v_d;
    logic [B_BIT-1:0] k_q, k_d;
    logic [VW-1:0]    nxt_q, nxt_d;
    logic             nxt_v_q, nxt_v_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic             mv_q, mv_d;
    logic [D_BIT-1:0] md_q, md_d;
    logic             ml_q, ml_d;

    logic             acc;
    logic             ld;
    logic             head_done;
    logic             can_rd;
    logic [2:0]       commit;
    logic [VW-1:0]    head_vec;
    logic [B_BIT-1:0] head_k;
    logic [D_BIT-1:0] head_word;

    assign oS_READY = (state_q == IDLE) || (state_q == LOAD);
    assign acc      = iS_VALID & oS_READY;
    assign oWE      = acc ? (N_BANK'(1) << cnt_q[B_BIT-1:0]) : '0;
    assign oADDR_WR = cnt_q[CW-1:B_BIT];
    assign oDATA_WR = acc ? {iS_DATA[D_BIT-2], iS_DATA} : '0;
    assign oSTART   = (state_q == START);
    assign oBUSY    = (state_q != IDLE);
    assign oERR     = err_q;
    assign oADDR_RD = addr_q;
    assign oM_VALID = mv_q;
    assign oM_DATA  = md_q;
    assign oM_LAST  = ml_q;

    // Head of the vector queue: held current vector, else the read landing now.
    assign head_vec  = cur_v_q ? cur_q : iDATA_RD;
    assign head_k    = cur_v_q ? k_q : '0;
    assign head_word = head_vec[int'(head_k)*D_BIT +: D_BIT];
    assign ld        = (state_q == UNLOAD) & (cur_v_q | infl_q)
                     & (~mv_q | iM_READY);
    assign head_done = ld & (head_k == LAST_K);

    // Every issued or in-flight vector owns one of the two slots.
    assign commit = 3'(cur_v_q) + 3'(nxt_v_q) + 3'(infl_q) + 3'(rdv_q);
    assign can_rd = (commit - 3'(head_done)) < 3'd2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        err_d   = err_q;
        addr_d  = addr_q;
        rdv_d   = 1'b0;
        infl_d  = rdv_q;
        cur_d   = cur_q;
        cur_v_d = cur_v_q;
        k_d     = k_q;
        nxt_d   = nxt_q;
        nxt_v_d = nxt_v_q;
        wcnt_d  = wcnt_q;
        mv_d    = mv_q;
        md_d    = md_q;
        ml_d    = ml_q;

        unique case (state_q)
            IDLE: if (acc) begin
                err_d   = 1'b0;
                cnt_d   = cnt_q + CW'(1);
                state_d = LOAD;
            end
            LOAD: if (acc) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_N) state_d = START;
            end
            START: begin
                to_d    = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                // oERR lands exactly TO_CYC cycles after the oSTART cycle.
                if (!iRDY) begin
                    state_d = WAIT_HI;
                end else if (to_q == TO_LIM) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            WAIT_HI: if (iRDY) begin
                state_d = UNLOAD;
                addr_d  = '0;
                rdv_d   = 1'b1;
                wcnt_d  = '0;
            end
            UNLOAD: begin
                if (can_rd && addr_q != LAST_A) begin
                    rdv_d  = 1'b1;
                    addr_d = addr_q + A_BIT'(1);
                end
                if (mv_q && iM_READY && ml_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            mv_d   = 1'b1;
            md_d   = head_word;
            ml_d   = (wcnt_q == LAST_N);
            wcnt_d = wcnt_q + CW'(1);
        end else if (iM_READY) begin
            mv_d = 1'b0;
            ml_d = 1'b0;
        end

        if (cur_v_q) begin
            if (head_done) begin
                cur_d   = nxt_v_q ? nxt_q : iDATA_RD;
                cur_v_d = nxt_v_q | infl_q;
                k_d     = '0;
                nxt_d   = iDATA_RD;
                nxt_v_d = nxt_v_q & infl_q;
            end else begin
                if (ld) k_d = k_q + B_BIT'(1);
                if (infl_q) begin
                    nxt_d   = iDATA_RD;
                    nxt_v_d = 1'b1;
                end
            end
        end else if (infl_q) begin
            cur_d   = iDATA_RD;
            cur_v_d = 1'b1;
            k_d     = ld ? B_BIT'(1) : '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rdv_q   <= 1'b0;
            infl_q  <= 1'b0;
            cur_q   <= '0;
            cur_v_q <= 1'b0;
            k_q     <= '0;
            nxt_q   <= '0;
            nxt_v_q <= 1'b0;
            wcnt_q  <= '0;
            mv_q    <= 1'b0;
            md_q    <= '0;
            ml_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rdv_q   <= rdv_d;
            infl_q  <= infl_d;
            cur_q   <= cur_d;
            cur_v_q <= cur_v_d;
            k_q     <= k_d;
            nxt_q   <= nxt_d;
            nxt_v_q <= nxt_v_d;
            wcnt_q  <= wcnt_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            ml_q    <= ml_d;
        end
    end
endmodule

// File: doc/fht_stream_io.md
# fht_stream_io

Parametrised streaming front/back-end for the banked FHT core. It accepts a serial sample stream over a valid/ready handshake and sign-extends each sample. Samples are scattered across N_BANK interleaved RAM banks, and the block issues the core start strobe and waits for completion. The transform result is then returned as a serial valid/ready stream in natural index order. It sits between the ADC/DMA side and the core's load, start, ready and read ports, replacing hand-driven per-bank WE/address sequencing.

## Interface
- D_BIT, 16, core word width; input samples are D_BIT-1 bits.
- A_BIT, 8, bank address width; frame length N = N_BANK·2^A_BIT.
- N_BANK, 4, bank count, power of two ≥ 2.
- B_BIT, 2, log2(N_BANK).
- TO_CYC, 16, cycles allowed for core ready to fall after start.
- iCLK  in  1  clock.
- iRESET  in  1  reset, asynchronous, active-low.
- iS_VALID / oS_READY  in/out  1  input-stream handshake.
- iS_DATA  in  D_BIT-1  signed sample.
- oWE  out  N_BANK  one-hot bank write enable.
- oADDR_WR  out  A_BIT  load address.
- oDATA_WR  out  D_BIT  sign-extended sample.
- oSTART  out  1  core start strobe.
- iRDY  in  1  core ready: high when idle or done, low while computing.
- oADDR_RD  out  A_BIT  read address, common to all banks.
- iDATA_RD  in  N_BANK·D_BIT  packed bank outputs; bank k is bits [k·D_BIT +: D_BIT]; 1-cycle read latency.
- oM_VALID / iM_READY  out/in  1  output-stream handshake.
- oM_DATA  out  D_BIT  result word.
- oM_LAST  out  1  high on word N-1.
- oBUSY  out  1  high in any state other than IDLE.
- oERR  out  1  sticky core-timeout flag.

## Operation
- States: IDLE, LOAD, START, WAIT_LO, WAIT_HI, UNLOAD.
- IDLE:
  - oS_READY=1.
  - The first accepted sample (iS_VALID & oS_READY) is written and the state moves to LOAD.
- Loading:
  - Sample n is written to bank n mod N_BANK at address n / N_BANK.
  - Write is combinational from the handshake: oWE = iS_VALID & oS_READY decoded to the bank, with oDATA_WR = {iS_DATA[D_BIT-2], iS_DATA}.
- LOAD:
  - Sample counter is B_BIT+A_BIT bits.
  - Accepting sample N-1 goes to START. oS_READY drops the next cycle and stays 0 until the state returns to IDLE.
- START:
  - oSTART=1 for exactly one cycle, then WAIT_LO with the timeout counter cleared.
- WAIT_LO:
  - Waits for iRDY=0, then WAIT_HI.
  - If the counter reaches TO_CYC, set oERR and return to IDLE without unloading.
- WAIT_HI:
  - Waits for iRDY=1, then UNLOAD. No timeout applies.
- UNLOAD:
  - Reads address a and emits bank words 0..N_BANK-1 of that vector, giving natural index a·N_BANK+k.
  - Two-entry vector buffer (current, next). The next address is prefetched as soon as the next slot is free or is being freed, so there are no bubbles while iM_READY=1.
  - oM_DATA/oM_VALID are registered. Data is held stable while oM_VALID & !iM_READY.
  - The word-N-1 transfer returns to IDLE.
- oADDR_RD is don't-care outside UNLOAD but must not be X after reset.
- Clearing oERR: it clears only on the first sample accepted in IDLE.
- Reset mid-operation: all counters and buffers clear and the state returns to IDLE. Samples already written are abandoned, and no oSTART is issued after reset.

## Timing
- Reset values of outputs:
  - 0: oWE, oADDR_WR, oDATA_WR, oSTART, oADDR_RD, oM_VALID, oM_DATA, oM_LAST, oBUSY, oERR.
  - 1: oS_READY.
- Load rate: one sample per cycle.
- Last sample accepted at cycle t → oSTART=1 at t+1.
- iRDY rising at cycle u (WAIT_HI) → oADDR_RD=0 at u+1, first oM_VALID at u+3.
- Steady output: 1 word per cycle with iM_READY=1.
- Backpressure:
  - Deasserting iM_READY for any number of cycles loses and duplicates no word.
  - At most 2 vectors are buffered.
  - No read is issued unless a slot is guaranteed.
- iRDY already low on the START cycle counts as a fall on the first WAIT_LO cycle.

## Test plan
- Reset check: assert iRESET=0 → all outputs at their reset values, with oS_READY=1.
- Load mapping: N_BANK=4, A_BIT=3 (N=32); stream samples 0..31 with 15-bit value 0x4000|n for n ≥ 16 → sample 5 on oWE=0010 at addr 1, sample 17 on oWE=0010 at addr 4 with oDATA_WR=0xC011 (bit 14 extended into bit 15), and oSTART at exactly one cycle after sample 31.
- Full frame: a core model with iRDY low for 40 cycles and an identity RAM → 32 outputs in order 0..31, oM_LAST only on the 32nd, contiguous with iM_READY=1.
- Backpressure: toggle iM_READY with random 50% duty → same 32-word sequence, no drops or duplicates, oM_DATA stable while stalled.
- Timeout: iRDY held 1 after oSTART → oERR=1 at TO_CYC cycles after START, state IDLE with oS_READY=1, no oM_VALID; the next accepted sample clears oERR.
- Mid-operation reset: pulse iRESET low during UNLOAD at word 10 → outputs return to reset values; a fresh frame afterwards completes normally.
